// File: rtl/bist_pkg.sv
// -----------------------------------------------------------------------------
// bist_pkg
// Shared definitions for the multiplier BIST controller: FSM state encoding,
// default geometry, pattern-generator seed and taps, and the fault-free MISR
// signature for the default 2x2 multiplier.
// -----------------------------------------------------------------------------
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_COMPARE = 2'd2,
    ST_DONE    = 2'd3
  } bist_state_t;

  localparam int BIST_W    = 2;
  localparam int BIST_NVEC = 16;

  // First non-zero pattern; the all-zero vector is applied before it.
  localparam logic [2*BIST_W-1:0] BIST_SEED      = 4'b0001;

  // Feedback taps for x^4 + x^3 + 1: new LSB = p[3] ^ p[2].
  localparam logic [2*BIST_W-1:0] BIST_LFSR_TAPS = 4'b1100;

  // Signature left in the MISR after the 16-vector sequence with a
  // fault-free multiplier.
  localparam logic [2*BIST_W-1:0] BIST_GOLDEN_SIG = 4'b0100;

endpackage

// File: rtl/bist_misr.sv
// -----------------------------------------------------------------------------
// bist_misr
// Multiple-input signature register compacting one product per enabled cycle.
//   s0 <= s[N-1] ^ d0 ; si <= s[i-1] ^ di ; s[N-1] additionally folds in s[N-1]
// Ports:
//   clk  in   clock, rising edge
//   clr  in   synchronous clear (dominates en)
//   en   in   absorb d this cycle
//   d    in   DATA_W-bit product to compact
//   sig  out  current signature
// -----------------------------------------------------------------------------
module bist_misr #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] sig
);

  function automatic logic [DATA_W-1:0] misr_next(
    input logic [DATA_W-1:0] s,
    input logic [DATA_W-1:0] din
  );
    logic [DATA_W-1:0] n;
    n[0] = s[DATA_W-1] ^ din[0];
    for (int i = 1; i < DATA_W; i++) begin
      n[i] = s[i-1] ^ din[i];
    end
    // The top stage also feeds back on itself.
    n[DATA_W-1] = n[DATA_W-1] ^ s[DATA_W-1];
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= misr_next(sig, d);
    end
  end

endmodule

// File: rtl/bist_mul_ctrl.sv
// -----------------------------------------------------------------------------
// bist_mul_ctrl
// BIST controller for the array multiplier. In IDLE the functional operands
// pass straight through; in test mode the controller drives an exhaustive
// LFSR vector sequence, compacts the products in a MISR and reports pass/fail.
//
// Ports:
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-low
//   a_in, b_in     in   functional operands (W bits)
//   test_mode      in   level: high starts/holds a test, low aborts/returns
//   mul_a, mul_b   out  operands to the multiplier
//   mul_y          in   combinational product from the multiplier (2W bits)
//   y              out  mul_y in IDLE, MISR signature otherwise
//   busy           out  high in RUN and COMPARE
//   test_complete  out  high in DONE
//   test_good      out  pass flag, valid while test_complete is high
//   t_a, t_b       out  vector report
//
// Optional feature macro: BIST_FAIL_LOG_EN
//   defined   - per-vector product check; t_a/t_b latch the first failing
//               vector and test_good also requires no mismatch.
//   undefined - t_a/t_b show the current (in DONE: last) vector and
//               test_good is signature-only.
// -----------------------------------------------------------------------------
module bist_mul_ctrl
  import bist_pkg::*;
#(
  parameter int                 W          = BIST_W,
  parameter int                 NVEC       = BIST_NVEC,
  parameter logic [2*W-1:0]     GOLDEN_SIG = BIST_GOLDEN_SIG
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  input  logic           test_mode,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  output logic [2*W-1:0] y,
  output logic           busy,
  output logic           test_complete,
  output logic           test_good,
  output logic [W-1:0]   t_a,
  output logic [W-1:0]   t_b
);

  localparam int CW = $clog2(NVEC) + 1;

  bist_state_t    state;
  logic [2*W-1:0] p;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] misr_sig;
  logic           misr_clr;
  logic           misr_en;
  logic           last_vec;
  logic           sig_ok;

  function automatic logic [2*W-1:0] lfsr_next(input logic [2*W-1:0] v);
    return {v[2*W-2:0], ^(v & BIST_LFSR_TAPS)};
  endfunction

  assign last_vec = (cnt == CW'(NVEC - 1));

  // Operand mux: functional path in IDLE, pattern register otherwise.
  assign mul_a = (state == ST_IDLE) ? a_in : p[2*W-1:W];
  assign mul_b = (state == ST_IDLE) ? b_in : p[W-1:0];
  assign y     = (state == ST_IDLE) ? mul_y : misr_sig;

  // Any path back to IDLE (reset, abort, DONE exit) leaves the MISR empty.
  assign misr_clr = !reset || (state == ST_IDLE) || !test_mode;
  assign misr_en  = (state == ST_RUN);

  bist_misr #(
    .DATA_W(2*W)
  ) u_misr (
    .clk (clk),
    .clr (misr_clr),
    .en  (misr_en),
    .d   (mul_y),
    .sig (misr_sig)
  );

`ifdef BIST_FAIL_LOG_EN
  logic           fail_seen;
  logic [W-1:0]   fail_a;
  logic [W-1:0]   fail_b;
  logic [2*W-1:0] prod_chk;

  // Operands are zero-extended so the reference product is a full 2W bits.
  assign prod_chk = {{W{1'b0}}, p[2*W-1:W]} * {{W{1'b0}}, p[W-1:0]};

  always_ff @(posedge clk) begin
    if (!reset || (state == ST_IDLE) || !test_mode) begin
      fail_seen <= 1'b0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else if ((state == ST_RUN) && !fail_seen && (mul_y != prod_chk)) begin
      fail_seen <= 1'b1;
      fail_a    <= p[2*W-1:W];
      fail_b    <= p[W-1:0];
    end
  end

  assign t_a    = fail_a;
  assign t_b    = fail_b;
  assign sig_ok = (misr_sig == GOLDEN_SIG) && !fail_seen;
`else
  assign t_a    = p[2*W-1:W];
  assign t_b    = p[W-1:0];
  assign sig_ok = (misr_sig == GOLDEN_SIG);
`endif

  // Control FSM. Vector 0 (all zeros) is applied on the first RUN cycle, the
  // seed on the second, then the LFSR steps. The pattern is frozen on the
  // last RUN cycle so the last vector stays visible through DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      p             <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      test_complete <= 1'b0;
      test_good     <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          p   <= '0;
          cnt <= '0;
          if (test_mode) begin
            state <= ST_RUN;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!test_mode) begin
            state <= ST_IDLE;
            p     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == '0) begin
              p <= BIST_SEED;
            end else if (!last_vec) begin
              p <= lfsr_next(p);
            end
            if (last_vec) begin
              state <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (!test_mode) begin
            state <= ST_IDLE;
            p     <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            test_good     <= sig_ok;
            test_complete <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!test_mode) begin
            state         <= ST_IDLE;
            p             <= '0;
            cnt           <= '0;
            test_complete <= 1'b0;
            test_good     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_mul_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bist_mul_ctrl
// Scoreboard bench: stimulus pushes expected vectors and end-of-test results
// into queues; a monitor pops and compares while busy is high and when
// test_complete rises. Multiplier is modelled with an optional y[0] stuck-at-1.
// -----------------------------------------------------------------------------
module tb_bist_mul_ctrl;

  logic       clk;
  logic       reset;
  logic [1:0] a_in, b_in;
  logic       test_mode;
  logic [1:0] mul_a, mul_b;
  logic [3:0] mul_y;
  logic [3:0] y;
  logic       busy, test_complete, test_good;
  logic [1:0] t_a, t_b;
  logic       fault;

  int total = 0;
  int bad   = 0;

  // Expected t_a in DONE for the runs below (t_b is 00 in every case).
`ifdef BIST_FAIL_LOG_EN
  localparam logic [1:0] DONE_TA = 2'b00;
`else
  localparam logic [1:0] DONE_TA = 2'b10;
`endif

  // Hand-derived LFSR sequence {mul_a, mul_b}: 0000, seed, then x^4+x^3+1.
  logic [3:0] vec_tab [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                               4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  typedef struct packed {
    logic       good;
    logic [3:0] sig;
    logic [1:0] ta;
    logic [1:0] tb;
    logic [7:0] bcnt;
  } res_t;

  logic [3:0] vec_q[$];
  res_t       res_q[$];

  logic       mon_en    = 1'b0;
  logic       prev_busy = 1'b0;
  logic       prev_tc   = 1'b0;
  int         bcnt      = 0;

  assign mul_y = ({2'b00, mul_a} * {2'b00, mul_b}) | {3'b000, fault};

  bist_mul_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .a_in          (a_in),
    .b_in          (b_in),
    .test_mode     (test_mode),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_y         (mul_y),
    .y             (y),
    .busy          (busy),
    .test_complete (test_complete),
    .test_good     (test_good),
    .t_a           (t_a),
    .t_b           (t_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: one vector per busy cycle, one result record per DONE entry.
  always @(negedge clk) begin
    if (mon_en) begin
      if (busy === 1'b1) begin
        if (!prev_busy) bcnt = 0;
        bcnt++;
        if (vec_q.size() == 0) begin
          check("vec_unexpected", {28'd0, mul_a, mul_b}, 32'hFFFF_FFFF);
        end else begin
          logic [3:0] ev;
          ev = vec_q.pop_front();
          check("vector", {28'd0, mul_a, mul_b}, {28'd0, ev});
        end
      end
      if (test_complete === 1'b1 && !prev_tc) begin
        if (res_q.size() == 0) begin
          check("res_unexpected", 32'd1, 32'd0);
        end else begin
          res_t r;
          r = res_q.pop_front();
          check("done_good", {31'd0, test_good}, {31'd0, r.good});
          check("done_sig",  {28'd0, y},         {28'd0, r.sig});
          check("done_ta",   {30'd0, t_a},       {30'd0, r.ta});
          check("done_tb",   {30'd0, t_b},       {30'd0, r.tb});
          check("busy_cycles", bcnt,             {24'd0, r.bcnt});
          check("done_busy", {31'd0, busy},      32'd0);
        end
      end
      prev_busy = (busy === 1'b1);
      prev_tc   = (test_complete === 1'b1);
    end
  end

  task automatic push_vecs(input int n);
    for (int i = 0; i < n; i++) vec_q.push_back(vec_tab[(i > 15) ? 15 : i]);
  endtask

  task automatic push_res(input logic g, input logic [3:0] s);
    res_t r;
    r.good = g;
    r.sig  = s;
    r.ta   = DONE_TA;
    r.tb   = 2'b00;
    r.bcnt = 8'd17;
    res_q.push_back(r);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (test_complete !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (test_complete !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: test_complete=%b want 1", nm, test_complete);
    end
    @(negedge clk); #1;
  endtask

  task automatic run_full(input string nm, input logic g, input logic [3:0] s);
    push_vecs(17);
    push_res(g, s);
    test_mode = 1'b1;
    wait_done(nm);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"}, {31'd0, busy},          32'd0);
    check({nm, "_tc"},   {31'd0, test_complete}, 32'd0);
    check({nm, "_tg"},   {31'd0, test_good},     32'd0);
    check({nm, "_ta"},   {30'd0, t_a},           32'd0);
    check({nm, "_tb"},   {30'd0, t_b},           32'd0);
  endtask

  initial begin
    reset = 1'b0; test_mode = 1'b0; fault = 1'b0;
    a_in = 2'b01; b_in = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_mul_a", {30'd0, mul_a}, 32'h1);
    check("reset_mul_b", {30'd0, mul_b}, 32'h2);
    check("reset_y",     {28'd0, y},     32'h2);
    reset = 1'b1;
    mon_en = 1'b1;

    // Normal mode passthrough, no latency.
    a_in = 2'b11; b_in = 2'b10; #1;
    check("norm_mul_a", {30'd0, mul_a}, 32'h3);
    check("norm_mul_b", {30'd0, mul_b}, 32'h2);
    check("norm_y",     {28'd0, y},     32'h6);
    a_in = 2'b10; b_in = 2'b01; #1;
    check("norm_y2",    {28'd0, y},     32'h2);
    a_in = 2'b11; b_in = 2'b11;
    @(posedge clk); #1;

    // Fault-free full run, then DONE held for 20 cycles.
    run_full("pass1", 1'b1, 4'h4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("hold_tc",   {31'd0, test_complete}, 32'd1);
      check("hold_tg",   {31'd0, test_good},     32'd1);
      check("hold_y",    {28'd0, y},             32'h4);
      check("hold_busy", {31'd0, busy},          32'd0);
      check("hold_ta",   {30'd0, t_a},           {30'd0, DONE_TA});
    end
    test_mode = 1'b0;
    @(posedge clk); #1;
    check("exit_tc", {31'd0, test_complete}, 32'd0);
    check("exit_y",  {28'd0, y},             32'h9);

    // Multiplier y[0] stuck-at-1.
    fault = 1'b1;
    @(posedge clk); #1;
    run_full("stuck", 1'b0, 4'h5);
    test_mode = 1'b0;
    @(posedge clk); #1;
    fault = 1'b0;
    check("stuck_exit_tc", {31'd0, test_complete}, 32'd0);

    // Abort after 8 RUN cycles, then a full passing rerun.
    push_vecs(8);
    test_mode = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1 test_mode = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", {31'd0, busy},          32'd0);
    check("abort_tc",   {31'd0, test_complete}, 32'd0);
    check("abort_tg",   {31'd0, test_good},     32'd0);
    check("abort_y",    {28'd0, y},             32'h9);
    run_full("rerun", 1'b1, 4'h4);
    test_mode = 1'b0;
    @(posedge clk); #1;

    // Reset at RUN cycle 10 with test_mode held high.
    a_in = 2'b01; b_in = 2'b11;
    push_vecs(11);
    test_mode = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    check("midrst_mul_a", {30'd0, mul_a}, 32'h1);
    check("midrst_y",     {28'd0, y},     32'h3);
    reset = 1'b1;
    run_full("after_rst", 1'b1, 4'h4);
    test_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("vec_q_empty", vec_q.size(), 32'd0);
    check("res_q_empty", res_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
